// File: rtl/eq_fir_pkg.sv
// eq_fir_pkg: shared constants and types for the equalizer FIR datapath.
// Provides sample/accumulator types, FSM states and the default coefficient image.
package eq_fir_pkg;

    localparam int SAMPLE_W = 16;
    localparam int FRAC_W   = 15;
    localparam int NUM_TAPS = 64;
    localparam int CNT_W    = $clog2(NUM_TAPS);
    localparam int PROD_W   = 2 * SAMPLE_W;
    localparam int ACC_W    = PROD_W + CNT_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic  vld;
        logic  first;
        logic  last;
        prod_t prod;
    } s1_t;

    // Unity-ish default: every tap weighted by 2^-7.
    localparam logic [NUM_TAPS*SAMPLE_W-1:0] DEF_COEF =
        {NUM_TAPS{16'h0100}};

endpackage

// File: rtl/fir_coeff_rom.sv
// fir_coeff_rom: NUM_TAPS x DATA_W signed coefficient ROM, asynchronous read.
// Ports: addr (tap index) -> coef (coefficient word). Word k sits at COEF_INIT[k*DATA_W +: DATA_W].
module fir_coeff_rom
    import eq_fir_pkg::*;
#(
    parameter int NUM_TAPS = eq_fir_pkg::NUM_TAPS,
    parameter int DATA_W   = eq_fir_pkg::SAMPLE_W,
    parameter logic [NUM_TAPS*DATA_W-1:0] COEF_INIT = eq_fir_pkg::DEF_COEF,
    localparam int AW = $clog2(NUM_TAPS)
) (
    input  logic [AW-1:0]     addr,
    output logic [DATA_W-1:0] coef
);

    logic [DATA_W-1:0] mem [NUM_TAPS];

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            mem[k] = COEF_INIT[k*DATA_W +: DATA_W];
        end
    end

    assign coef = mem[addr];

endmodule

// File: rtl/fir_tap_accumulator.sv
// fir_tap_accumulator: sweeps NUM_TAPS taps through a 2-stage MAC and emits one rounded
// Q1.15 sample per sweep. Ports: clk, rst (async, high), i_en, i_count, i_tap_sample ->
// o_sample, o_valid (1-clk pulse), o_busy (FSM in RUN). Coefficients come from COEF_INIT.
// Macro FIR_ACC_SATURATE_EN: clamp the rounded result instead of wrapping it.
module fir_tap_accumulator
    import eq_fir_pkg::*;
#(
    parameter int NUM_TAPS = eq_fir_pkg::NUM_TAPS,
    parameter int DATA_W   = eq_fir_pkg::SAMPLE_W,
    parameter int ACC_W    = eq_fir_pkg::ACC_W,
    parameter logic [NUM_TAPS*DATA_W-1:0] COEF_INIT = eq_fir_pkg::DEF_COEF,
    localparam int CNT_BITS = $clog2(NUM_TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [CNT_BITS-1:0] i_count,
    input  logic [DATA_W-1:0]   i_tap_sample,
    output logic [DATA_W-1:0]   o_sample,
    output logic                o_valid,
    output logic                o_busy
);

    localparam int PW = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);

    state_t state;
    state_t state_nx;

    logic is_first;
    logic is_last;
    logic tap_vld;

    logic [DATA_W-1:0]       coef;
    logic signed [PW-1:0]    prod_d;
    logic signed [PW-1:0]    prod_r;
    logic                    vld1;
    logic                    first1;
    logic                    last1;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;
    logic [DATA_W-1:0]       fmt;

    assign is_first = (i_count == '0);
    assign is_last  = (i_count == CNT_BITS'(NUM_TAPS - 1));

    fir_coeff_rom #(
        .NUM_TAPS  (NUM_TAPS),
        .DATA_W    (DATA_W),
        .COEF_INIT (COEF_INIT)
    ) u_rom (
        .addr (i_count),
        .coef (coef)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (i_en && is_first) state_nx = ST_RUN;
            ST_RUN:  if (is_last && !i_en) state_nx = ST_IDLE;
        endcase
    end

    // The start tap is taken in the IDLE cycle that sees count 0.
    always_comb begin
        o_busy  = (state == ST_RUN);
        tap_vld = o_busy || (i_en && is_first);
    end

    assign prod_d = PW'($signed(i_tap_sample)) * PW'($signed(coef));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r <= '0;
            vld1   <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
        end else begin
            prod_r <= prod_d;
            vld1   <= tap_vld;
            first1 <= is_first;
            last1  <= is_last;
        end
    end

    assign prod_x = ACC_W'(prod_r);
    assign sum    = acc_r + prod_x;
    assign rnd    = sum + HALF;

`ifdef FIR_ACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI =
        (ACC_W'(1) << (DATA_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

    logic signed [ACC_W-1:0] r;

    always_comb begin
        r = rnd >>> FRAC_W;
        if (r > SAT_HI) begin
            fmt = DATA_W'(SAT_HI);
        end else if (r < SAT_LO) begin
            fmt = DATA_W'(SAT_LO);
        end else begin
            fmt = DATA_W'(r);
        end
    end
`else
    always_comb begin
        fmt = DATA_W'(rnd >>> FRAC_W);
    end
`endif

    // first1 reloads the accumulator so back-to-back sweeps need no clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= '0;
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= vld1 && last1;
            if (vld1) begin
                acc_r <= first1 ? prod_x : sum;
            end
            if (vld1 && last1) begin
                o_sample <= fmt;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// tb_fir_tap_accumulator: three DUTs (random, DC and full-scale coefficients) share one
// free-running counter; a sweep-level arithmetic model predicts every output.
module tb_fir_tap_accumulator;

    localparam int NT = 64;
    localparam int DW = 16;

    function automatic logic [NT*DW-1:0] mk_rand(input int unsigned seed);
        logic [NT*DW-1:0] v;
        int unsigned x;
        x = seed;
        v = '0;
        for (int k = 0; k < NT; k++) begin
            x = x * 32'd1103515245 + 32'd12345;
            v[k*DW +: DW] = x[30:15];
        end
        return v;
    endfunction

    localparam logic [NT*DW-1:0] C_RND = mk_rand(32'd7);
    localparam logic [NT*DW-1:0] C_DC  = {NT{16'h0100}};
    localparam logic [NT*DW-1:0] C_OVF = {NT{16'h7fff}};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  cnt;
    logic [15:0] smp  [3];
    logic [15:0] osmp [3];
    logic        ovld [3];
    logic        obsy [3];

    int nchk = 0;
    int nerr = 0;
    int npulse = 0;
    int mode = 1;

    logic [15:0] cf [3][NT];
    longint      macc [3];
    logic        m_act = 1'b0;
    logic        pv = 1'b0;
    logic [15:0] pes  [3];
    logic [15:0] held [3];

    always #5 clk = ~clk;

    fir_tap_accumulator #(.COEF_INIT(C_RND)) u_rnd (
        .clk(clk), .rst(rst), .i_en(en), .i_count(cnt),
        .i_tap_sample(smp[0]), .o_sample(osmp[0]),
        .o_valid(ovld[0]), .o_busy(obsy[0]));

    fir_tap_accumulator #(.COEF_INIT(C_DC)) u_dc (
        .clk(clk), .rst(rst), .i_en(en), .i_count(cnt),
        .i_tap_sample(smp[1]), .o_sample(osmp[1]),
        .o_valid(ovld[1]), .o_busy(obsy[1]));

    fir_tap_accumulator #(.COEF_INIT(C_OVF)) u_ovf (
        .clk(clk), .rst(rst), .i_en(en), .i_count(cnt),
        .i_tap_sample(smp[2]), .o_sample(osmp[2]),
        .o_valid(ovld[2]), .o_busy(obsy[2]));

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fmt(input longint s);
        longint r;
        r = (s + 64'sd16384) >>> 15;
`ifdef FIR_ACC_SATURATE_EN
        if (r > 64'sd32767) r = 64'sd32767;
        else if (r < -64'sd32768) r = -64'sd32768;
`endif
        return r[15:0];
    endfunction

    task automatic step();
        logic        ev;
        logic [15:0] es [3];
        logic [15:0] xs;
        smp[0] = 16'($urandom);
        case (mode)
            1:       smp[1] = 16'h4000;
            2:       smp[1] = 16'hc000;
            default: smp[1] = 16'($urandom);
        endcase
        smp[2] = 16'h7fff;
        ev = 1'b0;
        for (int i = 0; i < 3; i++) es[i] = 16'h0;
        if (cnt == 6'd0 && (m_act || en)) begin
            m_act = 1'b1;
            for (int i = 0; i < 3; i++) macc[i] = 0;
        end
        if (m_act) begin
            for (int i = 0; i < 3; i++)
                macc[i] += longint'($signed(smp[i])) * longint'($signed(cf[i][cnt]));
            if (cnt == 6'd63) begin
                ev = 1'b1;
                for (int i = 0; i < 3; i++) es[i] = fmt(macc[i]);
                m_act = en;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), 16'(obsy[i]), 16'(m_act));
            chk($sformatf("valid%0d", i), 16'(ovld[i]), 16'(pv));
            xs = pv ? pes[i] : held[i];
            chk($sformatf("sample%0d", i), osmp[i], xs);
            held[i] = xs;
        end
        if (ovld[1]) npulse++;
        pv = ev;
        for (int i = 0; i < 3; i++) pes[i] = es[i];
        cnt = cnt + 6'd1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rst_checks();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), 16'(ovld[i]), 16'h0);
            chk($sformatf("rst_sample%0d", i), osmp[i], 16'h0);
            chk($sformatf("rst_busy%0d", i), 16'(obsy[i]), 16'h0);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst_checks();
        m_act = 1'b0;
        pv = 1'b0;
        for (int i = 0; i < 3; i++) held[i] = 16'h0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        for (int k = 0; k < NT; k++) begin
            cf[0][k] = C_RND[k*DW +: DW];
            cf[1][k] = C_DC[k*DW +: DW];
            cf[2][k] = C_OVF[k*DW +: DW];
        end
        for (int i = 0; i < 3; i++) begin
            held[i] = 16'h0;
            pes[i] = 16'h0;
            smp[i] = 16'h0;
        end
        rst = 1'b1;
        en = 1'b0;
        cnt = 6'd0;
        #2;
        rst_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;

        en = 1'b1;
        mode = 1;
        run(130);
        chk("t2_dc", osmp[1], 16'h2000);
`ifdef FIR_ACC_SATURATE_EN
        chk("t4_ovf", osmp[2], 16'h7fff);
`else
        chk("t4_ovf", osmp[2], 16'hff80);
`endif
        npulse = 0;
        run(640);
        chk("t2_pulses", 16'(npulse), 16'd10);

        while (cnt != 6'd0) step();
        mode = 2;
        run(66);
        chk("t3_neg", osmp[1], 16'he000);

        mode = 0;
        run(640);

        while (cnt != 6'd30) step();
        en = 1'b0;
        npulse = 0;
        run(200);
        chk("t5_drop_pulses", 16'(npulse), 16'd1);
        chk("t5_drop_busy", 16'(obsy[1]), 16'h0);

        while (cnt != 6'd10) step();
        en = 1'b1;
        mode = 1;
        npulse = 0;
        n = 0;
        while (npulse == 0 && n < 200) begin
            step();
            n++;
        end
        chk("t5_rise_latency", 16'(n), 16'd119);
        chk("t5_rise_dc", osmp[1], 16'h2000);

        while (cnt != 6'd40) step();
        pulse_rst();
        npulse = 0;
        run(26);
        chk("t6_no_valid", 16'(npulse), 16'd0);
        run(64);
        chk("t6_pulses", 16'(npulse), 16'd1);
        chk("t6_dc", osmp[1], 16'h2000);

        mode = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) == 0) en = !en;
            if ($urandom_range(0, 599) == 0) pulse_rst();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
